// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: arbiter FSM encoding, grant identifiers and
// default bus widths used across the wb_* blocks.
package wb_pkg;

  localparam int WB_DATA_WIDTH_DEF  = 32;
  localparam int WB_ADDR_WIDTH_DEF  = 32;
  localparam int WB_SEL_WIDTH_DEF   = 4;
  localparam int TIMEOUT_CYCLES_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OWN_M0 = 2'd1,
    ST_OWN_M1 = 2'd2,
    ST_ABORT  = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_M0 = 1'b0,
    GRANT_M1 = 1'b1
  } grant_t;

endpackage

// File: rtl/wb_timeout_counter.sv
// Stall counter for a bus tenure; terminal fires combinationally on the
// stalled cycle that brings the count up to LIMIT.
module wb_timeout_counter #(
  parameter int LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic count,
  input  logic clear,
  output logic terminal
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LAST_VALUE = CW'(LIMIT - 1);

  logic [CW-1:0] count_reg;

  // count_reg holds the number of stalls already seen, so the current
  // stalled cycle is the LIMIT-th one when count_reg equals LIMIT-1.
  assign terminal = count && (count_reg == LAST_VALUE);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_reg <= '0;
    end else if (clear || terminal) begin
      count_reg <= '0;
    end else if (count) begin
      count_reg <= count_reg + CW'(1);
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Two-master Wishbone arbiter with alternating tie-break, locked tenures and
// an abort path for slaves that stall longer than TIMEOUT_CYCLES.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int WB_DATA_WIDTH  = WB_DATA_WIDTH_DEF,
  parameter int WB_ADDR_WIDTH  = WB_ADDR_WIDTH_DEF,
  parameter int WB_SEL_WIDTH   = WB_SEL_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [WB_ADDR_WIDTH-1:0] wb_m0_addr_i,
  input  logic [WB_DATA_WIDTH-1:0] wb_m0_data_i,
  input  logic                     wb_m0_we_i,
  input  logic [WB_SEL_WIDTH-1:0]  wb_m0_sel_i,
  input  logic                     wb_m0_stb_i,
  input  logic                     wb_m0_cyc_i,
  output logic                     wb_m0_ack_o,
  output logic                     wb_m0_err_o,
  output logic [WB_DATA_WIDTH-1:0] wb_m0_data_o,
  input  logic [WB_ADDR_WIDTH-1:0] wb_m1_addr_i,
  input  logic [WB_DATA_WIDTH-1:0] wb_m1_data_i,
  input  logic                     wb_m1_we_i,
  input  logic [WB_SEL_WIDTH-1:0]  wb_m1_sel_i,
  input  logic                     wb_m1_stb_i,
  input  logic                     wb_m1_cyc_i,
  output logic                     wb_m1_ack_o,
  output logic                     wb_m1_err_o,
  output logic [WB_DATA_WIDTH-1:0] wb_m1_data_o,
  output logic [WB_ADDR_WIDTH-1:0] wb_s_addr_o,
  output logic [WB_DATA_WIDTH-1:0] wb_s_data_o,
  output logic                     wb_s_we_o,
  output logic [WB_SEL_WIDTH-1:0]  wb_s_sel_o,
  output logic                     wb_s_stb_o,
  output logic                     wb_s_cyc_o,
  input  logic                     wb_s_ack_i,
  input  logic [WB_DATA_WIDTH-1:0] wb_s_data_i,
  output logic                     timeout_o
);

  arb_state_t state_reg;
  grant_t     last_grant_reg;
  grant_t     abort_owner_reg;

  logic own_m0;
  logic own_m1;
  logic owner_cyc;
  logic owner_stb;
  logic stall;
  logic terminal;

  assign own_m0 = (state_reg == ST_OWN_M0);
  assign own_m1 = (state_reg == ST_OWN_M1);

  assign owner_cyc = (own_m0 & wb_m0_cyc_i) | (own_m1 & wb_m1_cyc_i);
  assign owner_stb = (own_m0 & wb_m0_stb_i) | (own_m1 & wb_m1_stb_i);

  // An ack in the same cycle keeps the counter from hitting terminal, so
  // ack always beats timeout.
  assign stall = owner_cyc & owner_stb & ~wb_s_ack_i;

  wb_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_counter (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .count    (stall),
    .clear    (~stall),
    .terminal (terminal)
  );

  assign wb_m0_ack_o  = own_m0 & wb_s_ack_i;
  assign wb_m1_ack_o  = own_m1 & wb_s_ack_i;
  assign wb_m0_err_o  = own_m0 & terminal;
  assign wb_m1_err_o  = own_m1 & terminal;
  assign timeout_o    = terminal;
  assign wb_m0_data_o = wb_s_data_i;
  assign wb_m1_data_o = wb_s_data_i;

  always_comb begin
    wb_s_addr_o = '0;
    wb_s_data_o = '0;
    wb_s_we_o   = 1'b0;
    wb_s_sel_o  = '0;
    wb_s_stb_o  = 1'b0;
    wb_s_cyc_o  = 1'b0;
    if (own_m0) begin
      wb_s_addr_o = wb_m0_addr_i;
      wb_s_data_o = wb_m0_data_i;
      wb_s_we_o   = wb_m0_we_i;
      wb_s_sel_o  = wb_m0_sel_i;
      wb_s_stb_o  = wb_m0_stb_i;
      wb_s_cyc_o  = wb_m0_cyc_i;
    end else if (own_m1) begin
      wb_s_addr_o = wb_m1_addr_i;
      wb_s_data_o = wb_m1_data_i;
      wb_s_we_o   = wb_m1_we_i;
      wb_s_sel_o  = wb_m1_sel_i;
      wb_s_stb_o  = wb_m1_stb_i;
      wb_s_cyc_o  = wb_m1_cyc_i;
    end
  end

  // last_grant starts at m1 so the first tie after reset goes to m0.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg       <= ST_IDLE;
      last_grant_reg  <= GRANT_M1;
      abort_owner_reg <= GRANT_M0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (wb_m0_cyc_i && (!wb_m1_cyc_i || last_grant_reg == GRANT_M1)) begin
            state_reg      <= ST_OWN_M0;
            last_grant_reg <= GRANT_M0;
          end else if (wb_m1_cyc_i) begin
            state_reg      <= ST_OWN_M1;
            last_grant_reg <= GRANT_M1;
          end
        end
        ST_OWN_M0: begin
          if (!wb_m0_cyc_i) begin
            state_reg <= ST_IDLE;
          end else if (terminal) begin
            state_reg       <= ST_ABORT;
            abort_owner_reg <= GRANT_M0;
          end
        end
        ST_OWN_M1: begin
          if (!wb_m1_cyc_i) begin
            state_reg <= ST_IDLE;
          end else if (terminal) begin
            state_reg       <= ST_ABORT;
            abort_owner_reg <= GRANT_M1;
          end
        end
        ST_ABORT: begin
          if ((abort_owner_reg == GRANT_M0) ? !wb_m0_cyc_i : !wb_m1_cyc_i) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: grants, ties, locked bursts, timeout abort,
// ack-beats-timeout and asynchronous reset mid-tenure.
module tb_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdat, m1_wdat;
  logic          m0_we, m1_we;
  logic [SW-1:0] m0_sel, m1_sel;
  logic          m0_stb, m1_stb, m0_cyc, m1_cyc;
  logic          m0_ack, m1_ack, m0_err, m1_err;
  logic [DW-1:0] m0_rdat, m1_rdat;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdat;
  logic          s_we;
  logic [SW-1:0] s_sel;
  logic          s_stb, s_cyc;
  logic          s_ack;
  logic [DW-1:0] s_rdat;
  logic          timeout;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  wb_arbiter #(
    .WB_DATA_WIDTH (DW),
    .WB_ADDR_WIDTH (AW),
    .WB_SEL_WIDTH  (SW),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .wb_m0_addr_i(m0_addr),
    .wb_m0_data_i(m0_wdat),
    .wb_m0_we_i  (m0_we),
    .wb_m0_sel_i (m0_sel),
    .wb_m0_stb_i (m0_stb),
    .wb_m0_cyc_i (m0_cyc),
    .wb_m0_ack_o (m0_ack),
    .wb_m0_err_o (m0_err),
    .wb_m0_data_o(m0_rdat),
    .wb_m1_addr_i(m1_addr),
    .wb_m1_data_i(m1_wdat),
    .wb_m1_we_i  (m1_we),
    .wb_m1_sel_i (m1_sel),
    .wb_m1_stb_i (m1_stb),
    .wb_m1_cyc_i (m1_cyc),
    .wb_m1_ack_o (m1_ack),
    .wb_m1_err_o (m1_err),
    .wb_m1_data_o(m1_rdat),
    .wb_s_addr_o (s_addr),
    .wb_s_data_o (s_wdat),
    .wb_s_we_o   (s_we),
    .wb_s_sel_o  (s_sel),
    .wb_s_stb_o  (s_stb),
    .wb_s_cyc_o  (s_cyc),
    .wb_s_ack_i  (s_ack),
    .wb_s_data_i (s_rdat),
    .timeout_o   (timeout)
  );

  `define CHK(tag, obs, exp) \
    begin \
      tests++; \
      assert ((obs) === (exp)) else begin \
        fails++; \
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp); \
      end \
    end

  always @(negedge clk) begin
    tests++;
    if ((m0_rdat !== s_rdat) || (m1_rdat !== s_rdat)) begin
      fails++;
      $display("FAIL mon_rdat: m0 %0h m1 %0h slave %0h", m0_rdat, m1_rdat, s_rdat);
    end
    tests++;
    if ((m0_ack & m1_ack) !== 1'b0) begin
      fails++;
      $display("FAIL mon_ack_excl: m0_ack %0b m1_ack %0b", m0_ack, m1_ack);
    end
  end

  // Next cycle: inputs change 1 time unit after the rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Outputs are sampled on the falling edge of the current cycle.
  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    m0_addr = 32'h0000_00A0; m0_wdat = 32'h1111_0000; m0_we = 1'b0; m0_sel = 4'hF;
    m1_addr = 32'h0000_00B0; m1_wdat = 32'h2222_0000; m1_we = 1'b1; m1_sel = 4'h3;
    m0_stb = 1'b0; m0_cyc = 1'b0; m1_stb = 1'b0; m1_cyc = 1'b0;
    s_ack  = 1'b0; s_rdat = 32'h1234_5678;

    // Reset state
    #2;
    `CHK("rst_s_cyc", s_cyc, 1'b0)
    `CHK("rst_s_addr", s_addr, 32'h0)
    `CHK("rst_acks", {m0_ack, m1_ack, m0_err, m1_err, timeout}, 5'b0)
    `CHK("rst_m0_rdat", m0_rdat, 32'h1234_5678)
    `CHK("rst_m1_rdat", m1_rdat, 32'h1234_5678)
    do_reset();
    $display("[TB] reset state checked");

    // m0 read, slave acks on the third owned cycle
    next_cycle(); m0_addr = 32'h100; m0_cyc = 1'b1; m0_stb = 1'b1;
    sample(); `CHK("rd_t0_s_cyc", s_cyc, 1'b0)
    next_cycle(); sample();
    `CHK("rd_t1_s_cyc", s_cyc, 1'b1)
    `CHK("rd_t1_s_addr", s_addr, 32'h100)
    `CHK("rd_t1_s_sel", s_sel, 4'hF)
    next_cycle(); sample();
    `CHK("rd_t2_ack", {m0_ack, m1_ack}, 2'b00)
    next_cycle(); s_ack = 1'b1; s_rdat = 32'hDEAD_BEEF;
    sample();
    `CHK("rd_t3_s_cyc", s_cyc, 1'b1)
    `CHK("rd_t3_m0_ack", m0_ack, 1'b1)
    `CHK("rd_t3_m1_ack", m1_ack, 1'b0)
    `CHK("rd_t3_m0_rdat", m0_rdat, 32'hDEAD_BEEF)
    next_cycle(); s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    sample(); `CHK("rd_t4_s_cyc", s_cyc, 1'b0)
    $display("[TB] m0 single read transaction done");

    // Alternating ties after reset: m0, then m1, then m0
    do_reset();
    m0_addr = 32'hA0;
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    next_cycle(); sample();
    `CHK("tie1_s_addr", s_addr, 32'hA0)
    `CHK("tie1_s_cyc", s_cyc, 1'b1)
    next_cycle(); m0_cyc = 1'b0; m0_stb = 1'b0;
    next_cycle(); m0_cyc = 1'b1; m0_stb = 1'b1;
    sample(); `CHK("tie_idle_s_cyc", s_cyc, 1'b0)
    next_cycle(); s_ack = 1'b1;
    sample();
    `CHK("tie2_s_addr", s_addr, 32'hB0)
    `CHK("tie2_s_we", s_we, 1'b1)
    `CHK("tie2_acks", {m0_ack, m1_ack}, 2'b01)
    next_cycle(); s_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    next_cycle(); m1_cyc = 1'b1; m1_stb = 1'b1;
    next_cycle(); sample();
    `CHK("tie3_s_addr", s_addr, 32'hA0)
    next_cycle(); m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    next_cycle();
    $display("[TB] alternating tie transactions done");

    // m1 locked 4-beat burst, m0 requests during beat 2
    m1_cyc = 1'b1; m1_stb = 1'b1;
    next_cycle(); s_ack = 1'b1;
    for (int b = 0; b < 4; b++) begin
      if (b == 1) begin m0_cyc = 1'b1; m0_stb = 1'b1; end
      sample();
      `CHK("burst_s_addr", s_addr, 32'hB0)
      `CHK("burst_acks", {m0_ack, m1_ack}, 2'b01)
      if (b < 3) next_cycle();
    end
    next_cycle(); s_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    next_cycle(); sample();
    `CHK("burst_gap_s_cyc", s_cyc, 1'b0)
    next_cycle(); sample();
    `CHK("burst_m0_s_addr", s_addr, 32'hA0)
    `CHK("burst_m0_s_cyc", s_cyc, 1'b1)
    next_cycle(); m0_cyc = 1'b0; m0_stb = 1'b0;
    next_cycle();
    $display("[TB] m1 locked burst transaction done");

    // Timeout: slave never acks m0
    m0_cyc = 1'b1; m0_stb = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      next_cycle(); sample();
      `CHK("to_stall_err", {m0_err, timeout}, 2'b00)
    end
    next_cycle(); sample();
    `CHK("to_t4_m0_err", m0_err, 1'b1)
    `CHK("to_t4_timeout", timeout, 1'b1)
    `CHK("to_t4_m0_ack", m0_ack, 1'b0)
    `CHK("to_t4_m1_err", m1_err, 1'b0)
    next_cycle(); sample();
    `CHK("to_abort_s_cyc", s_cyc, 1'b0)
    `CHK("to_abort_pulse", {m0_err, timeout}, 2'b00)
    next_cycle(); s_ack = 1'b1;
    sample();
    `CHK("to_abort_hold_s_cyc", s_cyc, 1'b0)
    `CHK("to_abort_ack_ignored", m0_ack, 1'b0)
    next_cycle(); s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    next_cycle(); m1_cyc = 1'b1; m1_stb = 1'b1;
    sample(); `CHK("to_idle_s_cyc", s_cyc, 1'b0)
    next_cycle(); sample();
    `CHK("to_after_m1_s_addr", s_addr, 32'hB0)
    next_cycle(); m1_cyc = 1'b0; m1_stb = 1'b0;
    next_cycle();
    $display("[TB] timeout abort transaction done");

    // Ack on the 4th cycle wins over the timeout
    m0_cyc = 1'b1; m0_stb = 1'b1;
    repeat (3) next_cycle();
    next_cycle(); s_ack = 1'b1;
    sample();
    `CHK("race_m0_ack", m0_ack, 1'b1)
    `CHK("race_err_to", {m0_err, timeout}, 2'b00)
    next_cycle(); s_ack = 1'b0;
    sample(); `CHK("race_still_owned", s_cyc, 1'b1)
    next_cycle(); m0_cyc = 1'b0; m0_stb = 1'b0;
    next_cycle();
    $display("[TB] ack-vs-timeout transaction done");

    // Asynchronous reset in the middle of an m0 tenure
    m0_cyc = 1'b1; m0_stb = 1'b1;
    next_cycle(); sample();
    `CHK("ar_pre_s_cyc", s_cyc, 1'b1)
    s_ack = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    `CHK("ar_s_cyc", s_cyc, 1'b0)
    `CHK("ar_ack_err", {m0_ack, m0_err, timeout}, 3'b000)
    s_ack = 1'b0;
    m1_cyc = 1'b1; m1_stb = 1'b1;
    next_cycle(); rst_n = 1'b1;
    next_cycle(); sample();
    `CHK("ar_tie_s_addr", s_addr, 32'hA0)
    next_cycle(); m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    next_cycle();
    $display("[TB] async reset transaction done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter WB_DATA_WIDTH, default 32, data bus width.
REQ-002 SHALL have parameter WB_ADDR_WIDTH, default 32, address bus width.
REQ-003 SHALL have parameter WB_SEL_WIDTH, default 4, byte-select width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, stalled-cycle limit before abort; legal range 1..65535.
REQ-005 SHALL have port clk_i input 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_i input 1: reset, asynchronous, active-low.
REQ-007 SHALL have ports wb_m0_addr_i / wb_m1_addr_i, input, WB_ADDR_WIDTH: master addresses.
REQ-008 SHALL have ports wb_m0_data_i / wb_m1_data_i, input, WB_DATA_WIDTH: master write data.
REQ-009 SHALL have ports wb_m0_we_i / wb_m1_we_i, input, 1: master write enables.
REQ-010 SHALL have ports wb_m0_sel_i / wb_m1_sel_i, input, WB_SEL_WIDTH: master byte selects.
REQ-011 SHALL have ports wb_m0_stb_i / wb_m1_stb_i and wb_m0_cyc_i / wb_m1_cyc_i, input, 1 each: master strobe and cycle.
REQ-012 SHALL have ports wb_m0_ack_o / wb_m1_ack_o, output, 1: per-master acknowledge.
REQ-013 SHALL have ports wb_m0_err_o / wb_m1_err_o, output, 1: per-master timeout error.
REQ-014 SHALL have ports wb_m0_data_o / wb_m1_data_o, output, WB_DATA_WIDTH: read data.
REQ-015 SHALL have ports wb_s_addr_o, wb_s_data_o, wb_s_we_o, wb_s_sel_o, wb_s_stb_o, wb_s_cyc_o, output, widths as master side: shared slave port (feeds wb_mux CPU side).
REQ-016 SHALL have ports wb_s_ack_i input 1 and wb_s_data_i input WB_DATA_WIDTH: slave response.
REQ-017 SHALL have port timeout_o output 1: one-cycle pulse per abort.

Function
REQ-018 SHALL implement FSM states IDLE, OWN_M0, OWN_M1, ABORT.
REQ-019 In IDLE, cyc_i high on one master only SHALL move to that master's OWN state next cycle (1-cycle grant latency).
REQ-020 In IDLE with both cyc_i high, SHALL grant the master not granted last (last_grant register); equal history after reset favours m0.
REQ-021 In OWN_Mx, wb_s_* outputs SHALL combinationally mirror master x; wb_s_cyc_o/stb_o SHALL be 0 in IDLE and ABORT, other slave outputs 0 there.
REQ-022 wb_mx_ack_o SHALL equal wb_s_ack_i only while in OWN_Mx; non-owner ack_o/err_o SHALL be 0.
REQ-023 wb_m0_data_o and wb_m1_data_o SHALL both carry wb_s_data_i at all times.
REQ-024 Ownership SHALL persist while owner cyc_i stays high (locked bursts); owner dropping cyc_i SHALL return to IDLE next cycle; minimum one IDLE cycle between tenures.
REQ-025 wb_s_ack_i in IDLE or ABORT SHALL be ignored.
REQ-026 Stall counter, width ceil(log2(TIMEOUT_CYCLES+1)), SHALL increment each OWN cycle with owner stb high and wb_s_ack_i low, clear on ack, on stb low, and on leaving OWN.
REQ-027 Counter reaching TIMEOUT_CYCLES SHALL, same cycle, assert owner err_o and timeout_o for one cycle, suppress ack_o, and move to ABORT next cycle.
REQ-028 ABORT SHALL hold until the aborted master drops cyc_i, then go IDLE next cycle; last_grant SHALL update on every grant including aborted tenures.
REQ-029 Simultaneous wb_s_ack_i and counter terminal value SHALL treat ack as winning: ack delivered, no err, no abort.

Reset
REQ-030 rst_i low SHALL asynchronously force IDLE, counter 0, last_grant = m1 (so m0 wins first tie), all outputs 0 except data_o which mirror wb_s_data_i.
REQ-031 Reset asserted mid-tenure SHALL drop wb_s_cyc_o immediately with no ack or err to the owner.

Structure
REQ-032 FSM state encoding and default width localparams SHALL live in the shared wb package used by wb_mux/wb_timer.
REQ-033 The stall counter SHALL be a sub-module wb_timeout_counter (inputs count/clear, output terminal).

Verification
REQ-034 m0 read only: cyc/stb at t0, slave acks at t3 with 0xDEADBEEF -> wb_s_cyc_o high t1..t3, m0 ack at t3 with data 0xDEADBEEF, m1 ack never high.
REQ-035 Both request at t0 after reset -> m0 granted t1; m0 releases, both still requesting -> m1 granted after one IDLE cycle; next tie -> m0.
REQ-036 m1 4-beat locked burst, m0 requests mid-burst -> m0 waits; granted only after m1 drops cyc, one IDLE cycle between.
REQ-037 TIMEOUT_CYCLES=4, slave never acks -> m0 err_o and timeout_o pulse on 4th stalled cycle, wb_s_cyc_o low next cycle, IDLE one cycle after m0 drops cyc.
REQ-038 TIMEOUT_CYCLES=4, ack on 4th stalled cycle -> ack delivered, no err, no timeout_o.
REQ-039 rst_i low during m0 tenure -> wb_s_cyc_o 0 asynchronously, no ack/err; after release, first tie grants m0.
